// File: rtl/tnk3_video_timing.sv
// TNK III raster timing generator.
// Pixel/line counters advanced by the CK1 pixel enable, tile latch enables,
// the vblank-latched flip pair INV/INVn, registered blanking/sync status and
// the vblank interrupt request with CPU acknowledge.
module tnk3_video_timing #(
    parameter int H_TOTAL   = 384,
    parameter int H_VISIBLE = 256,
    parameter int HS_START  = 288,
    parameter int HS_END    = 320,
    parameter int V_TOTAL   = 264,
    parameter int V_VISIBLE = 224,
    parameter int VS_START  = 240,
    parameter int VS_END    = 244
) (
    input  logic       clk,
    input  logic       VIDEO_RST,
    input  logic       CK1,
    input  logic       FLIP_REQ,
    input  logic       IRQ_ACK,
    output logic [7:0] X,
    output logic       H8,
    output logic [4:0] Y,
    output logic [2:0] VROW,
    output logic       H1n,
    output logic       H2n,
    output logic       H0n_cen,
    output logic       H2n_cen,
    output logic       VLK,
    output logic       VFLGn,
    output logic       INV,
    output logic       INVn,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VBL_IRQ
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_VIS  = 9'(H_VISIBLE);
    localparam logic [8:0] HS_S   = 9'(HS_START);
    localparam logic [8:0] HS_E   = 9'(HS_END);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_VIS  = 9'(V_VISIBLE);
    localparam logic [8:0] VS_S   = 9'(VS_START);
    localparam logic [8:0] VS_E   = 9'(VS_END);

    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic       inv_q, inv_d;
    logic       irq_q, irq_d;
    logic       hblank_q, hblank_d;
    logic       vblank_q, vblank_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       vbl_start;

    // Next raster position, vblank-start event and status derived from the
    // next position so the registered status lines up with the counters.
    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        vbl_start = 1'b0;
        if (CK1) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 9'd0;
                vcnt_d = (vcnt_q == V_LAST) ? 9'd0 : vcnt_q + 9'd1;
                vbl_start = (vcnt_d == V_VIS);
            end else begin
                hcnt_d = hcnt_q + 9'd1;
            end
        end

        inv_d = vbl_start ? FLIP_REQ : inv_q;

        // Set takes priority over a coincident acknowledge.
        if (vbl_start) begin
            irq_d = 1'b1;
        end else if (IRQ_ACK) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        hblank_d = (hcnt_d >= H_VIS);
        vblank_d = (vcnt_d >= V_VIS);
        hsync_d  = (hcnt_d >= HS_S) && (hcnt_d < HS_E);
        vsync_d  = (vcnt_d >= VS_S) && (vcnt_d < VS_E);
    end

    // Raster state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            hcnt_q   <= 9'd0;
            vcnt_q   <= 9'd0;
            inv_q    <= 1'b0;
            irq_q    <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            inv_q    <= inv_d;
            irq_q    <= irq_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign X    = hcnt_q[7:0];
    assign H8   = hcnt_q[8];
    assign Y    = vcnt_q[7:3] ^ {5{inv_q}};
    assign VROW = vcnt_q[2:0] ^ {3{inv_q}};
    assign H1n  = ~hcnt_q[1];
    assign H2n  = ~hcnt_q[2];

    // Latch enables fire in the same edge the counter advances, so downstream
    // Cen latches see the pre-advance hcnt.
    assign H0n_cen = CK1 & ~VIDEO_RST & hcnt_q[0];
    assign H2n_cen = CK1 & ~VIDEO_RST & (hcnt_q[1:0] == 2'd3);
    assign VLK     = CK1 & ~VIDEO_RST & (hcnt_q[2:0] == 3'd7);

    // Side-layer read port is enabled (low) whenever the frame is active.
    assign VFLGn   = vblank_q;
    assign INV     = inv_q;
    assign INVn    = ~inv_q;
    assign HBLANK  = hblank_q;
    assign VBLANK  = vblank_q;
    assign HSYNC   = hsync_q;
    assign VSYNC   = vsync_q;
    assign VBL_IRQ = irq_q;

endmodule

// File: tb/tb_tnk3_video_timing.sv
// Directed bench for tnk3_video_timing. Horizontal timing uses the default
// geometry; the vertical geometry is shortened so several frames fit a run.
module tb_tnk3_video_timing;

    localparam int HT  = 384;
    localparam int VT  = 26;
    localparam int VV  = 20;
    localparam int VSS = 22;
    localparam int VSE = 24;

    logic       clk = 1'b0;
    logic       VIDEO_RST, CK1, FLIP_REQ, IRQ_ACK;
    logic [7:0] X;
    logic       H8;
    logic [4:0] Y;
    logic [2:0] VROW;
    logic       H1n, H2n, H0n_cen, H2n_cen, VLK, VFLGn, INV, INVn;
    logic       HBLANK, VBLANK, HSYNC, VSYNC, VBL_IRQ;

    int total = 0;
    int bad   = 0;
    int exp_h = 0;
    int exp_v = 0;
    int cnt_vlk, cnt_h2, cnt_h0;

    tnk3_video_timing #(
        .H_TOTAL(HT), .H_VISIBLE(256), .HS_START(288), .HS_END(320),
        .V_TOTAL(VT), .V_VISIBLE(VV), .VS_START(VSS), .VS_END(VSE)
    ) dut (
        .clk(clk), .VIDEO_RST(VIDEO_RST), .CK1(CK1), .FLIP_REQ(FLIP_REQ),
        .IRQ_ACK(IRQ_ACK), .X(X), .H8(H8), .Y(Y), .VROW(VROW), .H1n(H1n),
        .H2n(H2n), .H0n_cen(H0n_cen), .H2n_cen(H2n_cen), .VLK(VLK),
        .VFLGn(VFLGn), .INV(INV), .INVn(INVn), .HBLANK(HBLANK),
        .VBLANK(VBLANK), .HSYNC(HSYNC), .VSYNC(VSYNC), .VBL_IRQ(VBL_IRQ)
    );

    always #5 clk = ~clk;

    // One clk cycle: drive CK1, tally the latch enables seen before the edge,
    // then step the expected raster position.
    task automatic tick(input logic ck);
        CK1 = ck;
        #1;
        if (VLK === 1'b1) cnt_vlk++;
        if (H2n_cen === 1'b1) cnt_h2++;
        if (H0n_cen === 1'b1) cnt_h0++;
        @(posedge clk);
        #1;
        if (VIDEO_RST) begin
            exp_h = 0;
            exp_v = 0;
        end else if (ck) begin
            if (exp_h == HT - 1) begin
                exp_h = 0;
                exp_v = (exp_v == VT - 1) ? 0 : exp_v + 1;
            end else begin
                exp_h++;
            end
        end
    endtask

    task automatic run_to(input int h, input int v);
        logic [8:0] hv;
        for (int i = 0; i < 20000 && !(exp_h == h && exp_v == v); i++) tick(1'b1);
        hv = h[8:0];
        total++;
        if ({H8, X} !== hv) begin
            bad++;
            $display("FAIL run_to_pos got=%0d want=%0d", {H8, X}, hv);
        end
    endtask

    task automatic test_reset;
        VIDEO_RST = 1'b1;
        IRQ_ACK   = 1'b0;
        FLIP_REQ  = 1'b0;
        repeat (3) tick(1'b1);
        total++;
        if ({H8, X, Y, VROW, H1n, H2n} !== {1'b0, 8'd0, 5'd0, 3'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL rst_counters got=%b want=%b", {H8, X, Y, VROW, H1n, H2n},
                     {1'b0, 8'd0, 5'd0, 3'd0, 1'b1, 1'b1});
        end
        total++;
        if ({INV, INVn, VBL_IRQ, HBLANK, VBLANK, HSYNC, VSYNC, VFLGn} !== 8'b0100_0000) begin
            bad++;
            $display("FAIL rst_status got=%b want=01000000",
                     {INV, INVn, VBL_IRQ, HBLANK, VBLANK, HSYNC, VSYNC, VFLGn});
        end
        total++;
        if ({VLK, H2n_cen, H0n_cen} !== 3'b000) begin
            bad++;
            $display("FAIL rst_pulses got=%b want=000", {VLK, H2n_cen, H0n_cen});
        end
        VIDEO_RST = 1'b0;
        repeat (7) tick(1'b1);
        total++;
        if (X !== 8'd7) begin
            bad++;
            $display("FAIL pre_x7 got=%0d want=7", X);
        end
        CK1 = 1'b1;
        #1;
        total++;
        if ({VLK, H2n_cen, H0n_cen} !== 3'b111) begin
            bad++;
            $display("FAIL pulses_at_7 got=%b want=111", {VLK, H2n_cen, H0n_cen});
        end
        VIDEO_RST = 1'b1;
        #1;
        total++;
        if ({VLK, H2n_cen, H0n_cen} !== 3'b000) begin
            bad++;
            $display("FAIL pulses_gated got=%b want=000", {VLK, H2n_cen, H0n_cen});
        end
        tick(1'b1);
        VIDEO_RST = 1'b0;
        total++;
        if ({H8, X} !== 9'd0) begin
            bad++;
            $display("FAIL rst_from7 got=%0d want=0", {H8, X});
        end
        tick(1'b1);
        total++;
        if (X !== 8'd1) begin
            bad++;
            $display("FAIL first_ck1 got=%0d want=1", X);
        end
    endtask

    task automatic test_line_wrap;
        int hs_cnt;
        logic exp_hb, exp_hs;
        VIDEO_RST = 1'b1;
        tick(1'b1);
        VIDEO_RST = 1'b0;
        cnt_vlk = 0;
        cnt_h2  = 0;
        cnt_h0  = 0;
        hs_cnt  = 0;
        for (int i = 0; i < HT; i++) begin
            tick(1'b1);
            exp_hb = (exp_h >= 256);
            exp_hs = (exp_h >= 288) && (exp_h < 320);
            if (HSYNC === 1'b1) hs_cnt++;
            total++;
            if ({HBLANK, HSYNC} !== {exp_hb, exp_hs}) begin
                bad++;
                $display("FAIL line_hb_hs h=%0d got=%b want=%b", exp_h, {HBLANK, HSYNC},
                         {exp_hb, exp_hs});
            end
            if (exp_h == 256) begin
                total++;
                if ({H8, X} !== 9'h100) begin
                    bad++;
                    $display("FAIL h256 got=%0h want=100", {H8, X});
                end
            end
            if (exp_h == 5) begin
                total++;
                if ({H1n, H2n} !== 2'b10) begin
                    bad++;
                    $display("FAIL h5_levels got=%b want=10", {H1n, H2n});
                end
            end
        end
        total++;
        if ({H8, X, Y, VROW, HBLANK} !== {1'b0, 8'd0, 5'd0, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL line_end got=%b want=%b", {H8, X, Y, VROW, HBLANK},
                     {1'b0, 8'd0, 5'd0, 3'd1, 1'b0});
        end
        total++;
        if (hs_cnt != 32) begin
            bad++;
            $display("FAIL hsync_len got=%0d want=32", hs_cnt);
        end
        total++;
        if ({cnt_vlk, cnt_h2, cnt_h0} != {32'd48, 32'd96, 32'd192}) begin
            bad++;
            $display("FAIL pulse_counts got=%0d/%0d/%0d want=48/96/192", cnt_vlk, cnt_h2, cnt_h0);
        end
    endtask

    task automatic test_ck1_duty;
        repeat (5) tick(1'b0);
        total++;
        if ({X, VROW, HBLANK} !== {8'd0, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL hold_no_ck1 got=%b want=%b", {X, VROW, HBLANK}, {8'd0, 3'd1, 1'b0});
        end
        for (int i = 0; i < 12; i++) tick((i % 3) == 0);
        total++;
        if (X !== 8'd4) begin
            bad++;
            $display("FAIL duty_x got=%0d want=4", X);
        end
        tick(1'b1);
        CK1 = 1'b0;
        #1;
        total++;
        if (H0n_cen !== 1'b0) begin
            bad++;
            $display("FAIL h0n_no_ck1 got=%b want=0", H0n_cen);
        end
        CK1 = 1'b1;
        #1;
        total++;
        if (H0n_cen !== 1'b1) begin
            bad++;
            $display("FAIL h0n_ck1 got=%b want=1", H0n_cen);
        end
    endtask

    task automatic test_vblank_irq;
        int vs_lines;
        logic exp_vb, exp_vs;
        run_to(HT - 1, VV - 1);
        total++;
        if ({VBL_IRQ, VBLANK, VFLGn} !== 3'b000) begin
            bad++;
            $display("FAIL pre_vbl got=%b want=000", {VBL_IRQ, VBLANK, VFLGn});
        end
        tick(1'b1);
        total++;
        if ({VBL_IRQ, VBLANK, VFLGn, INV} !== 4'b1110) begin
            bad++;
            $display("FAIL vbl_start got=%b want=1110", {VBL_IRQ, VBLANK, VFLGn, INV});
        end
        total++;
        if ({H8, X, Y, VROW} !== {9'd0, 5'b00010, 3'b100}) begin
            bad++;
            $display("FAIL vbl_pos got=%b want=%b", {H8, X, Y, VROW}, {9'd0, 5'b00010, 3'b100});
        end
        repeat (10) tick(1'b1);
        total++;
        if (VBL_IRQ !== 1'b1) begin
            bad++;
            $display("FAIL irq_held got=%b want=1", VBL_IRQ);
        end
        IRQ_ACK = 1'b1;
        tick(1'b0);
        IRQ_ACK = 1'b0;
        total++;
        if ({VBL_IRQ, X} !== {1'b0, 8'd10}) begin
            bad++;
            $display("FAIL irq_ack got=%b want=%b", {VBL_IRQ, X}, {1'b0, 8'd10});
        end
        IRQ_ACK = 1'b1;
        tick(1'b1);
        IRQ_ACK = 1'b0;
        total++;
        if (VBL_IRQ !== 1'b0) begin
            bad++;
            $display("FAIL irq_ack_idle got=%b want=0", VBL_IRQ);
        end
        vs_lines = 0;
        for (int i = 0; i < 20000; i++) begin
            tick(1'b1);
            exp_vb = (exp_v >= VV);
            exp_vs = (exp_v >= VSS) && (exp_v < VSE);
            if (exp_h == 0 && VSYNC === 1'b1) vs_lines++;
            total++;
            if ({VBLANK, VSYNC} !== {exp_vb, exp_vs}) begin
                bad++;
                $display("FAIL vb_vs v=%0d h=%0d got=%b want=%b", exp_v, exp_h,
                         {VBLANK, VSYNC}, {exp_vb, exp_vs});
            end
            if (exp_h == 0 && exp_v == 0) break;
        end
        total++;
        if (vs_lines != 2) begin
            bad++;
            $display("FAIL vsync_lines got=%0d want=2", vs_lines);
        end
        total++;
        if ({H8, X, Y, VROW, VBLANK, VFLGn, VBL_IRQ} !== 20'd0) begin
            bad++;
            $display("FAIL frame_wrap got=%b want=0", {H8, X, Y, VROW, VBLANK, VFLGn, VBL_IRQ});
        end
    endtask

    task automatic test_irq_collision;
        run_to(HT - 1, VV - 1);
        IRQ_ACK = 1'b1;
        tick(1'b1);
        IRQ_ACK = 1'b0;
        total++;
        if (VBL_IRQ !== 1'b1) begin
            bad++;
            $display("FAIL set_ack_collision got=%b want=1", VBL_IRQ);
        end
        IRQ_ACK = 1'b1;
        tick(1'b1);
        IRQ_ACK = 1'b0;
        total++;
        if (VBL_IRQ !== 1'b0) begin
            bad++;
            $display("FAIL ack_after_collision got=%b want=0", VBL_IRQ);
        end
        run_to(0, 0);
    endtask

    task automatic test_flip;
        int inv_early;
        run_to(0, 10);
        FLIP_REQ  = 1'b1;
        inv_early = 0;
        for (int i = 0; i < 20000 && !(exp_h == HT - 1 && exp_v == VV - 1); i++) begin
            tick(1'b1);
            if (INV !== 1'b0 || INVn !== 1'b1) inv_early++;
        end
        total++;
        if (inv_early != 0) begin
            bad++;
            $display("FAIL inv_early got=%0d want=0", inv_early);
        end
        tick(1'b1);
        total++;
        if ({INV, INVn, Y, VROW} !== {1'b1, 1'b0, 5'b11101, 3'b011}) begin
            bad++;
            $display("FAIL flip_latch got=%b want=%b", {INV, INVn, Y, VROW},
                     {1'b1, 1'b0, 5'b11101, 3'b011});
        end
        run_to(0, 3);
        FLIP_REQ = 1'b0;
        run_to(0, 8);
        total++;
        if ({INV, INVn, Y, VROW} !== {1'b1, 1'b0, 5'b11110, 3'b111}) begin
            bad++;
            $display("FAIL flip_line8 got=%b want=%b", {INV, INVn, Y, VROW},
                     {1'b1, 1'b0, 5'b11110, 3'b111});
        end
        FLIP_REQ = 1'b1;
    endtask

    task automatic test_reset_mid;
        run_to(5, 23);
        total++;
        if ({VBL_IRQ, INV, VBLANK, VSYNC} !== 4'b1111) begin
            bad++;
            $display("FAIL mid_pre got=%b want=1111", {VBL_IRQ, INV, VBLANK, VSYNC});
        end
        VIDEO_RST = 1'b1;
        tick(1'b1);
        VIDEO_RST = 1'b0;
        total++;
        if ({H8, X, Y, VROW, H1n, H2n} !== {1'b0, 8'd0, 5'd0, 3'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL mid_rst_counters got=%b want=%b", {H8, X, Y, VROW, H1n, H2n},
                     {1'b0, 8'd0, 5'd0, 3'd0, 1'b1, 1'b1});
        end
        total++;
        if ({INV, INVn, VBL_IRQ, HBLANK, VBLANK, HSYNC, VSYNC, VFLGn} !== 8'b0100_0000) begin
            bad++;
            $display("FAIL mid_rst_status got=%b want=01000000",
                     {INV, INVn, VBL_IRQ, HBLANK, VBLANK, HSYNC, VSYNC, VFLGn});
        end
        repeat (3) tick(1'b1);
        total++;
        if ({X, Y, VBLANK, VFLGn} !== {8'd3, 5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_restart got=%b want=%b", {X, Y, VBLANK, VFLGn},
                     {8'd3, 5'd0, 1'b0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_ck1_duty();
        test_vblank_irq();
        test_irq_collision();
        test_flip();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
